addsub_pipe: RTL and testbench

//  Parametrised, pipelined adder/subtractor for the execute datapath; successor to the 32-bit combinational adder.

---
 rtl/addsub_pipe.sv | 126 ++++++++++++
 tb/tb_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is cut into STAGES slices, one slice per clock.
// Optional saturation is enabled by defining ADDSUB_PIPE_SAT_EN, which adds the `sat` input port.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             sub,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int W   = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;
  // STAGES=1 keeps a single unused intermediate slot so the array never has zero size.
  localparam int NI  = (STAGES > 1) ? STAGES - 1 : 1;

  // Operands ride along in full width; each stage consumes its own slice of a/b and fills its slice of s.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
`ifdef ADDSUB_PIPE_SAT_EN
    logic             sat;
`endif
  } stage_t;

  logic [STAGES-1:0] v_q, v_d;
  stage_t            st_q [NI];
  stage_t            src  [STAGES];
  stage_t            st_d [STAGES];
  logic              advance;

  logic [WIDTH-1:0]  res_d;
  logic              ovf_d;
  logic [WIDTH-1:0]  out_q;
  logic              carry_q, overflow_q, zero_q, negative_q;

  assign advance   = !v_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign out       = out_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

  // Slice adders: stage k adds bits [k*W +: W] with the carry registered by stage k-1.
  always_comb begin
    logic [W:0] slice;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    slice    = '0;
    v_d      = '0;
    v_d[0]   = in_valid;
    src[0]   = '0;
    src[0].a = ina;
    src[0].b = sub ? ~inb : inb;
    src[0].c = sub;
`ifdef ADDSUB_PIPE_SAT_EN
    src[0].sat = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
      v_d[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice   = {1'b0, src[k].a[k*W +: W]} + {1'b0, src[k].b[k*W +: W]} + {{W{1'b0}}, src[k].c};
      st_d[k] = src[k];
      st_d[k].s[k*W +: W] = slice[W-1:0];
      st_d[k].c = slice[W];
    end
  end

  // Result and flags of the operation leaving the last slice; overflow/carry always describe the raw sum.
  always_comb begin
    ovf_d = (st_d[STAGES-1].a[MSB] == st_d[STAGES-1].b[MSB]) &&
            (st_d[STAGES-1].s[MSB] != st_d[STAGES-1].a[MSB]);
    res_d = st_d[STAGES-1].s;
`ifdef ADDSUB_PIPE_SAT_EN
    if (st_d[STAGES-1].sat && ovf_d)
      res_d = st_d[STAGES-1].a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q        <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else if (advance) begin
      v_q <= v_d;
      if (v_d[STAGES-1]) begin
        out_q      <= res_d;
        carry_q    <= st_d[STAGES-1].c;
        overflow_q <= ovf_d;
        zero_q     <= (res_d == '0);
        negative_q <= res_d[MSB];
      end
    end
  end

  // NOTE: intermediate data registers are deliberately not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES - 1; k++) st_q[k] <= st_d[k];
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: a 32-bit/2-stage instance and a 16-bit/4-stage instance.
module tb_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_sub, a_sat, a_out_valid, a_out_ready;
  logic        a_carry, a_ovf, a_zero, a_neg;
  logic [31:0] a_ina, a_inb, a_out;

  logic        b_in_valid, b_in_ready, b_sub, b_sat, b_out_valid, b_out_ready;
  logic        b_carry, b_ovf, b_zero, b_neg;
  logic [15:0] b_ina, b_inb, b_out;

  addsub_pipe #(.WIDTH(32), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ina(a_ina), .inb(a_inb), .sub(a_sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(a_sat),
`endif
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out),
    .carry(a_carry), .overflow(a_ovf), .zero(a_zero), .negative(a_neg)
  );

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ina(b_ina), .inb(b_inb), .sub(b_sub),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(b_sat),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .carry(b_carry), .overflow(b_ovf), .zero(b_zero), .negative(b_neg)
  );

  typedef struct {
    logic [31:0] out;
    logic        c, v, z, n;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic        a_stall_prev = 1'b0;
  logic [31:0] a_prev_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit pipe: pops on every consumed output, checks hold-stability while stalled.
  always @(negedge clk) begin
    if (rst_n && a_out_valid) begin
      if (a_stall_prev) check("A_stall_stable", a_out, a_prev_out);
      if (a_out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL A_unexpected_output: got 0x%0h expected none", a_out);
        end else begin
          ea = qa.pop_front();
          check("A_out", a_out, ea.out);
          check("A_carry", 32'(a_carry), 32'(ea.c));
          check("A_overflow", 32'(a_ovf), 32'(ea.v));
          check("A_zero", 32'(a_zero), 32'(ea.z));
          check("A_negative", 32'(a_neg), 32'(ea.n));
          if (ea.lat) check("A_latency", 32'(cyc - ea.cyc), 32'd2);
        end
      end
    end
    a_stall_prev = rst_n && a_out_valid && !a_out_ready;
    a_prev_out   = a_out;
  end

  always @(negedge clk) begin
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL B_unexpected_output: got 0x%0h expected none", b_out);
      end else begin
        eb = qb.pop_front();
        check("B_out", 32'(b_out), eb.out);
        check("B_carry", 32'(b_carry), 32'(eb.c));
        check("B_overflow", 32'(b_ovf), 32'(eb.v));
        check("B_zero", 32'(b_zero), 32'(eb.z));
        check("B_negative", 32'(b_neg), 32'(eb.n));
        if (eb.lat) check("B_latency", 32'(cyc - eb.cyc), 32'd4);
      end
    end
  end

  // Present one operation from posedge+1 and hold it until accepted; expected result is queued on acceptance.
  task automatic issue_a(input logic s, input logic [31:0] x, input logic [31:0] y, input logic st,
                         input logic [31:0] eo, input logic ec, input logic ev, input logic ez,
                         input logic en, input bit lat);
    a_in_valid = 1'b1;
    a_ina = x;
    a_inb = y;
    a_sub = s;
    a_sat = st;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back('{eo, ec, ev, ez, en, cyc, lat});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL A_issue_timeout: in_ready stayed 0 expected 1 within 64 cycles");
    a_in_valid = 1'b0;
  endtask

  task automatic issue_b(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] eo, input logic ec, input logic ev, input logic ez,
                         input logic en);
    b_in_valid = 1'b1;
    b_ina = x;
    b_inb = y;
    b_sub = s;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back('{32'(eo), ec, ev, ez, en, cyc, 1'b1});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL B_issue_timeout: in_ready stayed 0 expected 1 within 64 cycles");
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_ina = '0; a_inb = '0; a_sub = 1'b0; a_sat = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_ina = '0; b_inb = '0; b_sub = 1'b0; b_sat = 1'b0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(a_out_valid), 32'd0);
    check("reset_out", a_out, 32'd0);
    check("reset_carry", 32'(a_carry), 32'd0);
    check("reset_overflow", 32'(a_ovf), 32'd0);
    check("reset_zero", 32'(a_zero), 32'd0);
    check("reset_negative", 32'(a_neg), 32'd0);
    check("reset_B_out_valid", 32'(b_out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors, consumer always ready.
    issue_a(0, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 1, 0, 1, 0, 1);
    issue_a(0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1, 0, 1, 1);
`ifdef ADDSUB_PIPE_SAT_EN
    issue_a(0, 32'h7FFFFFFF, 32'h00000001, 1, 32'h7FFFFFFF, 0, 1, 0, 0, 1);
    issue_a(1, 32'h80000000, 32'h00000001, 1, 32'h80000000, 1, 1, 0, 1, 1);
`endif
    issue_a(1, 32'h00000005, 32'h00000007, 0, 32'hFFFFFFFE, 0, 0, 0, 1, 1);
    issue_a(1, 32'h00000007, 32'h00000005, 0, 32'h00000002, 1, 0, 0, 0, 1);
    issue_a(1, 32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 1, 1, 0, 0, 1);
    issue_a(0, 32'h0000FFFF, 32'h00000001, 0, 32'h00010000, 0, 0, 0, 0, 1);
    issue_a(1, 32'h12345678, 32'h12345678, 0, 32'h00000000, 1, 0, 1, 0, 1);
    repeat (4) @(posedge clk);
    #1;

    // Stream four operations into a stalled consumer.
    a_out_ready = 1'b0;
    fork
      begin
        issue_a(0, 32'h00000001, 32'h00000002, 0, 32'h00000003, 0, 0, 0, 0, 0);
        issue_a(0, 32'h00000010, 32'h00000020, 0, 32'h00000030, 0, 0, 0, 0, 0);
        issue_a(1, 32'h00000064, 32'h00000001, 0, 32'h00000063, 1, 0, 0, 0, 0);
        issue_a(0, 32'h80000000, 32'h80000000, 0, 32'h00000000, 1, 1, 1, 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_low", 32'(a_in_ready), 32'd0);
        check("stall_out_valid_high", 32'(a_out_valid), 32'd1);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;

    // Two operations in flight, then a one-edge reset drops them.
    a_out_ready = 1'b0;
    issue_a(0, 32'h00000111, 32'h00000222, 0, 32'h00000333, 0, 0, 0, 0, 0);
    issue_a(0, 32'h00000444, 32'h00000555, 0, 32'h00000999, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    qa.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", 32'(a_out_valid), 32'd0);
    check("midreset_in_ready", 32'(a_in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;

    // 16-bit, 4-stage pipe: eight back-to-back operations.
    issue_b(0, 16'h000F, 16'h0001, 16'h0010, 0, 0, 0, 0);
    issue_b(0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0);
    issue_b(1, 16'h0000, 16'h0001, 16'hFFFF, 0, 0, 0, 1);
    issue_b(0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1);
    issue_b(1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0);
    issue_b(0, 16'h1234, 16'h4321, 16'h5555, 0, 0, 0, 0);
    issue_b(1, 16'hABCD, 16'h1234, 16'h9999, 1, 0, 0, 1);
    issue_b(0, 16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 0, 0, 1);

    for (int t = 0; t < 50 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk);
    @(negedge clk);
    check("A_all_results_drained", 32'(qa.size()), 32'd0);
    check("B_all_results_drained", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
